// File: rtl/alu_pkg.sv
// alu_pkg: shared code groups, sub-op codes, instruction field positions and sequencer states
package alu_pkg;
  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SLA = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_LE  = 3'b000;
  localparam logic [2:0] OP_LT  = 3'b001;
  localparam logic [2:0] OP_GE  = 3'b010;
  localparam logic [2:0] OP_GT  = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_NE  = 3'b101;
  localparam int F_CODE    = 11;
  localparam int F_RD      = 8;
  localparam int F_RS1     = 5;
  localparam int F_RS2     = 2;
  localparam int F_IMM_SEL = 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_code_check.sv
// alu_code_check: legality and group decode of a 5-bit ALU code
module alu_code_check
  import alu_pkg::*;
(
  input  logic [4:0] code,
  output logic       legal,
  output logic       is_arith,
  output logic       is_cmp
);
  logic [1:0] grp;
  logic [2:0] sub;
  assign grp = code[4:3];
  assign sub = code[2:0];
  assign is_arith = grp == GRP_ARITH;
  assign is_cmp = grp == GRP_CMP;
  assign legal = is_arith
    || (grp == GRP_LOGIC && sub inside {OP_AND, OP_OR, OP_XOR, OP_NOT})
    || (grp == GRP_SHIFT && sub inside {OP_SLL, OP_SRL, OP_SLA, OP_SRA})
    || (is_cmp && sub inside {OP_LE, OP_LT, OP_GE, OP_GT, OP_EQ, OP_NE});
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetches operands from an internal register file, drives the ALU,
// writes the result back and returns a completion record.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_code,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_rd,
  output logic              res_ovf,
  output logic              res_err,
  output logic              busy
);
  state_t state;
  logic [DATA_W-1:0] rf [NREGS];
  logic legal, is_arith, is_cmp;
  logic [DATA_W-1:0] wb_data;
  logic unused_bit;
  alu_code_check u_chk (
    .code    (alu_code),
    .legal   (legal),
    .is_arith(is_arith),
    .is_cmp  (is_cmp)
  );
  assign unused_bit = instr[0];
  assign instr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign wb_data = !legal ? '0 : is_cmp ? DATA_W'(alu_c[0]) : alu_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_code <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_rd <= '0;
      res_ovf <= 1'b0;
      res_err <= 1'b0;
    end else begin
      // preload sits first so a same-edge writeback to the same index overrides it
      if (ld_valid) rf[ld_addr] <= ld_data;
      case (state)
        IDLE: if (instr_valid) begin
          alu_a <= rf[instr[F_RS1 +: ADDR_W]];
          alu_b <= instr[F_IMM_SEL] ? DATA_W'(instr[F_RS2 +: 3]) : rf[instr[F_RS2 +: ADDR_W]];
          alu_code <= instr[F_CODE +: 5];
          res_rd <= instr[F_RD +: ADDR_W];
          state <= EXEC;
        end
        EXEC: begin
          res_valid <= 1'b1;
          res_data <= wb_data;
          res_ovf <= legal && is_arith && alu_ovf;
          res_err <= !legal;
          if (legal) rf[res_rd] <= wb_data;
          state <= RESP;
        end
        RESP: if (res_ready) begin
          res_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 16-bit ALU command interface: accepts instruction words through a valid/ready handshake and reads operands from an internal register file.
- Drives A, B and the 5-bit ALU code to the existing combinational ALU, then captures the result and overflow and writes the result back to the register file.
- Returns a completion record to the upstream controller; this is the block that sits between the instruction source and the ALU.

Parameters:
DATA_W, 16, operand/result width (must match ALU)
NREGS, 8, register file depth
ADDR_W, 3, register index width (log2 NREGS)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
instr_valid  in  1  instruction word present
instr_ready  out  1  sequencer can accept instruction
instr  in  16  [15:11] alu_code, [10:8] rd, [7:5] rs1, [4:2] rs2/imm3, [1] imm_sel, [0] ignored
ld_valid  in  1  direct register preload strobe
ld_addr  in  ADDR_W  preload target
ld_data  in  DATA_W  preload value
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_code  out  5  ALU function select
alu_c  in  DATA_W  ALU result
alu_ovf  in  1  ALU overflow
res_valid  out  1  completion record valid
res_ready  in  1  consumer accepts record
res_data  out  DATA_W  captured result
res_rd  out  ADDR_W  destination written
res_ovf  out  1  overflow, arithmetic group only
res_err  out  1  illegal code, no writeback
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all registers 0; alu_a/alu_b/alu_code 0; res_* 0; instr_ready 1; busy 0. Reset mid-operation aborts the instruction, with no writeback and no record.
- FSM: IDLE -> EXEC on instr_valid&&instr_ready; EXEC -> RESP unconditionally; RESP -> IDLE on res_ready.
- instr_ready = (state==IDLE).
- Accept at edge N:
  - alu_a/alu_b/alu_code are registered from rf[rs1], (imm_sel ? zero-extended imm3 : rf[rs2]) and code.
  - They are stable through EXEC.
- EXEC edge (N+1): capture alu_c/alu_ovf into res_data/res_ovf; write rf[rd] unless illegal; res_valid=1 from N+1 until handshake.
- Accept-to-res_valid latency is 1 cycle after the accept edge. Best-case throughput is one instruction per 3 cycles.
- Code groups (code[4:3]):
  - 00 arithmetic: sub-op 000-111 all legal; res_ovf = alu_ovf.
  - 01 logic: legal 000 AND, 001 OR, 010 XOR, 100 NOT.
  - 10 shift: legal 000 SLL, 001 SRL, 010 SLA, 011 SRA; shift amount is alu_b[3:0].
  - 11 compare: legal 000 LE, 001 LT, 010 GE, 011 GT, 100 EQ, 101 NE. Result is written as 16'h0000 or 16'h0001; bits [15:1] are forced 0 regardless of alu_c.
  - res_ovf is forced 0 for every non-arithmetic group.
- Illegal codes: 01011, 01101, 01110, 01111, 101xx, 11110, 11111.
  - Still pass through EXEC/RESP.
  - res_err=1, res_data=0, no register write.
  - alu_code is still driven as received.
- Preload: ld_valid writes rf[ld_addr]=ld_data in any state. If it coincides with the EXEC writeback to the same index, the writeback wins.
- Operand read at accept sees a preload from the same edge? No: it sees the old value (read-before-write).
- rd==rs1 or rd==rs2 is legal; operands are already latched, so the result overwrites the source.
- Record fields are held stable while res_valid && !res_ready. instr_valid is ignored outside IDLE.
- All arithmetic is DATA_W wide. Immediate is zero-extended with no sign extension.

Decomposition:
- Shared package alu_pkg holds:
  - group constants GRP_ARITH=2'b00, GRP_LOGIC=2'b01, GRP_SHIFT=2'b10, GRP_CMP=2'b11;
  - per-op 3-bit sub-codes;
  - the instruction field bit positions;
  - state encoding IDLE/EXEC/RESP.
- One sub-module, alu_code_check: combinational legality/group decode from the 5-bit code, giving legal, is_arith and is_cmp.
- The register file stays inline.

Test Plan:
- Preload r1=0x7FFF, r2=0x0001; ADD code 00000 rd=3 -> res_data=0x8000, res_ovf=1, rf[3]=0x8000, res_valid 1 cycle after accept.
- r1=0xF0F0, r2=0x0FF0, XOR 01010 rd=4 -> res_data=0xFF00, res_ovf=0 even if alu_ovf is driven 1.
- r5=0x8001, SRA 10011 imm_sel=1 imm3=1 rd=5 -> alu_b=0x0001, rf[5]=0xC000 (rd==rs1 overwrite).
- r1=0xFFFF(-1), r2=0x0002, LT 11001 -> res_data=0x0001; EQ 11100 -> 0x0000.
- Illegal code 01111 rd=6 with rf[6]=0x1234 -> res_err=1, res_data=0, rf[6] stays 0x1234.
- Hold res_ready=0 for 5 cycles with instr_valid=1: instr_ready stays 0 and the record stays stable. Assert rst mid-EXEC: all outputs go to 0 and there is no writeback.
